vertical_strip_capture: RTL and testbench

Front-end stage of the feature extractor that turns a raster-order grayscale pixel stream into one binarized vertical strip per frame. Each pixel is thresholded to 1 bit. The bit from the selected column of every row is packed into an IMG_H-bit strip word. The word is handed to the transition-counting stage over a valid/ready handshake. One frame is captured at a time, and input is back-pressured while a finished strip waits to be consumed.

---
 rtl/vertical_strip_capture_if.sv | 22 ++
 rtl/vertical_strip_capture.sv | 88 ++++++++
 tb/tb_vertical_strip_capture.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/vertical_strip_capture_if.sv
// vertical_strip_capture_if: pixel-in and strip-out valid/ready channels of the strip capture stage
interface vertical_strip_capture_if #(
  parameter int IMG_H = 200,
  parameter int PIX_W = 8
);
  logic             pix_valid;
  logic             pix_ready;
  logic             pix_sof;
  logic [PIX_W-1:0] pix_data;
  logic             strip_valid;
  logic             strip_ready;
  logic [IMG_H-1:0] strip_data;
  logic [15:0]      transitions;
  modport master (
    output pix_valid, pix_sof, pix_data, strip_ready,
    input  pix_ready, strip_valid, strip_data, transitions
  );
  modport slave (
    input  pix_valid, pix_sof, pix_data, strip_ready,
    output pix_ready, strip_valid, strip_data, transitions
  );
endinterface

// File: rtl/vertical_strip_capture.sv
// vertical_strip_capture: binarizes a raster pixel stream and packs one column per frame into a strip word.
// Optional feature macro STRIP_TRANSITIONS_EN enables the adjacent-row transition counter.
module vertical_strip_capture #(
  parameter int IMG_W = 300,
  parameter int IMG_H = 200,
  parameter int PIX_W = 8,
  localparam int XW = IMG_W > 1 ? $clog2(IMG_W) : 1,
  localparam int YW = IMG_H > 1 ? $clog2(IMG_H) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PIX_W-1:0]          threshold,
  input  logic [XW-1:0]             col_sel,
  output logic                      frame_err,
  vertical_strip_capture_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;
  state_t           state_q, state_d;
  logic [XW-1:0]    x_q, x_d, col_q, col_d, x_e, col_e;
  logic [YW-1:0]    y_q, y_d, y_e;
  logic [PIX_W-1:0] thr_q, thr_d, thr_e;
  logic [IMG_H-1:0] strip_q, strip_d, strip_e;
  logic             err_q, err_d;
  logic             acc, sof_beat, cap_beat, pix_bit, hit, x_end, y_end, last;
  assign acc      = bus.pix_valid && bus.pix_ready;
  assign sof_beat = acc && bus.pix_sof && state_q != HOLD;
  assign cap_beat = acc && (state_q == CAPTURE || sof_beat);
  // A sof beat acts on freshly sampled settings and a cleared strip in the same cycle
  assign thr_e    = sof_beat ? threshold : thr_q;
  assign col_e    = sof_beat ? col_sel : col_q;
  assign x_e      = sof_beat ? '0 : x_q;
  assign y_e      = sof_beat ? '0 : y_q;
  assign strip_e  = sof_beat ? '0 : strip_q;
  assign pix_bit  = bus.pix_data >= thr_e;
  assign hit      = cap_beat && x_e == col_e;
  assign x_end    = x_e == XW'(IMG_W - 1);
  assign y_end    = y_e == YW'(IMG_H - 1);
  assign last     = cap_beat && x_end && y_end;
  assign err_d    = acc && ((state_q == IDLE && !bus.pix_sof) ||
                            (state_q == CAPTURE && bus.pix_sof) ||
                            (sof_beat && 32'(col_sel) >= IMG_W));
  always_comb begin
    strip_d = strip_e;
    if (hit) strip_d[y_e] = pix_bit;
    thr_d   = thr_e;
    col_d   = col_e;
    x_d     = cap_beat ? (x_end ? '0 : x_e + XW'(1)) : x_q;
    y_d     = (cap_beat && x_end) ? (y_end ? '0 : y_e + YW'(1)) : y_e;
    state_d = state_q == HOLD ? (bus.strip_ready ? IDLE : HOLD) :
              last ? HOLD : cap_beat ? CAPTURE : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      thr_q   <= '0;
      strip_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      thr_q   <= thr_d;
      strip_q <= strip_d;
      err_q   <= err_d;
    end
  end
`ifdef STRIP_TRANSITIONS_EN
  logic [15:0] trans_q, trans_d, trans_e;
  assign trans_e = sof_beat ? '0 : trans_q;
  assign trans_d = (hit && y_e != '0 && pix_bit != strip_e[y_e - YW'(1)] && trans_e != 16'hFFFF) ?
                   trans_e + 16'd1 : trans_e;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trans_q <= '0;
    else        trans_q <= trans_d;
  end
  assign bus.transitions = trans_q;
`else
  assign bus.transitions = '0;
`endif
  assign bus.pix_ready   = rst_n && state_q != HOLD;
  assign bus.strip_valid = state_q == HOLD;
  assign bus.strip_data  = strip_q;
  assign frame_err       = err_q;
endmodule

// File: tb/tb_vertical_strip_capture.sv
// tb_vertical_strip_capture: directed frame table, corner sequences and random traffic against a frame-level model.
// Width 5 keeps an out-of-range col_sel (5..7) representable in the 3-bit select.
module tb_vertical_strip_capture;
  localparam int W = 5, H = 4;
`ifdef STRIP_TRANSITIONS_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, frame_err;
  logic [7:0] threshold = '0;
  logic [2:0] col_sel = '0;
  int checks = 0, errors = 0;
  vertical_strip_capture_if #(.IMG_H(H), .PIX_W(8)) bus ();
  vertical_strip_capture #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .threshold(threshold), .col_sel(col_sel),
    .frame_err(frame_err), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [7:0]      thr;
    logic [2:0]      col;
    logic [3:0][7:0] cp;
    logic [7:0]      other;
    logic [3:0]      strip;
    logic [15:0]     trans;
  } vec_t;
  vec_t vt[6];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] pixv(input vec_t v, input int i);
    return (i % W == int'(v.col)) ? v.cp[i / W] : v.other;
  endfunction
  task automatic send(input vec_t v, input int first, input int last, input logic exp_err);
    threshold = v.thr;
    col_sel = v.col;
    bus.strip_ready = 1'b0;
    for (int i = first; i <= last; i++) begin
      bus.pix_valid = 1'b1;
      bus.pix_sof = (i == 0);
      bus.pix_data = pixv(v, i);
      if (i == W * H - 1) chk("valid_before_last", bus.strip_valid, 0);
      tick();
      if (i == 0) chk("sof_frame_err", frame_err, exp_err);
    end
    bus.pix_valid = 1'b0;
    bus.pix_sof = 1'b0;
  endtask
  task automatic check_strip(input vec_t v);
    chk("strip_valid_rise", bus.strip_valid, 1);
    chk("strip_data", bus.strip_data, v.strip);
    chk("transitions", bus.transitions, TEN ? v.trans : 16'd0);
  endtask
  // Frame-level reference: buffers every accepted pixel of a frame, then derives the strip from the full image
  logic [7:0] mq[$];
  bit m_in = 0, m_pend = 0, m_err = 0;
  logic [3:0] m_last = '0, ms;
  logic [15:0] m_ltr = '0, mt;
  int m_thr = 0, m_col = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("m_rst_ready", bus.pix_ready, 0);
      chk("m_rst_valid", bus.strip_valid, 0);
      chk("m_rst_data", bus.strip_data, 0);
      chk("m_rst_err", frame_err, 0);
      m_in = 0; m_pend = 0; m_err = 0; m_last = '0; m_ltr = '0;
      mq.delete();
    end else begin
      chk("m_ready", bus.pix_ready, !m_pend);
      chk("m_valid", bus.strip_valid, m_pend);
      chk("m_frame_err", frame_err, m_err);
      if (!m_in) begin
        chk("m_strip", bus.strip_data, m_last);
        chk("m_trans", bus.transitions, m_ltr);
      end
      m_err = 0;
      if (m_pend) begin
        if (bus.strip_ready) m_pend = 0;
      end else if (bus.pix_valid) begin
        if (bus.pix_sof) begin
          m_err = m_in || int'(col_sel) >= W;
          m_in = 1; m_thr = threshold; m_col = col_sel; m_last = '0; m_ltr = '0;
          mq.delete();
          mq.push_back(bus.pix_data);
        end else if (m_in) mq.push_back(bus.pix_data);
        else m_err = 1;
        if (m_in && mq.size() == W * H) begin
          ms = '0; mt = '0;
          for (int y = 0; y < H; y++)
            if (m_col < W) ms[y] = int'(mq[y * W + m_col]) >= m_thr;
          if (TEN)
            for (int y = 1; y < H; y++)
              if (ms[y] != ms[y-1] && mt != 16'hFFFF) mt++;
          m_last = ms; m_ltr = mt; m_pend = 1; m_in = 0;
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t ve;
    int pos;
    vt[0] = '{8'd128, 3'd2, {8'd127, 8'd255, 8'd10,  8'd200}, 8'd0,   4'b0101, 16'd3};
    vt[1] = '{8'd128, 3'd0, {8'd255, 8'd255, 8'd0,   8'd0},   8'd255, 4'b1100, 16'd1};
    vt[2] = '{8'd0,   3'd4, {8'd0,   8'd9,   8'd5,   8'd0},   8'd0,   4'b1111, 16'd0};
    vt[3] = '{8'd255, 3'd1, {8'd254, 8'd255, 8'd255, 8'd254}, 8'd255, 4'b0110, 16'd2};
    vt[4] = '{8'd128, 3'd5, {8'd255, 8'd255, 8'd255, 8'd255}, 8'd255, 4'b0000, 16'd0};
    vt[5] = '{8'd100, 3'd3, {8'd99,  8'd100, 8'd99,  8'd100}, 8'd0,   4'b0101, 16'd3};
    ve    = '{8'd128, 3'd2, {8'd200, 8'd0,   8'd200, 8'd0},   8'd0,   4'b1010, 16'd3};
    bus.pix_valid = 1'b0; bus.pix_sof = 1'b0; bus.pix_data = '0; bus.strip_ready = 1'b0;
    repeat (3) tick();
    chk("rst_pix_ready", bus.pix_ready, 0);
    chk("rst_strip_valid", bus.strip_valid, 0);
    chk("rst_strip_data", bus.strip_data, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", bus.pix_ready, 1);
    chk("post_rst_valid", bus.strip_valid, 0);
    for (int k = 0; k < 6; k++) begin
      send(vt[k], 0, W * H - 1, int'(vt[k].col) >= W);
      check_strip(vt[k]);
      bus.strip_ready = 1'b1;
      tick();
      bus.strip_ready = 1'b0;
      chk("hs_valid_low", bus.strip_valid, 0);
      chk("hs_ready_high", bus.pix_ready, 1);
    end
    send(vt[0], 0, W * H - 1, 1'b0);
    check_strip(vt[0]);
    bus.pix_valid = 1'b1; bus.pix_sof = 1'b1; bus.pix_data = 8'd77;
    for (int c = 0; c < 5; c++) begin
      chk("bp_ready_low", bus.pix_ready, 0);
      chk("bp_strip_hold", bus.strip_data, vt[0].strip);
      tick();
    end
    bus.strip_ready = 1'b1;
    chk("bp_valid_c6", bus.strip_valid, 1);
    tick();
    bus.pix_valid = 1'b0; bus.pix_sof = 1'b0; bus.strip_ready = 1'b0;
    chk("bp_done_valid", bus.strip_valid, 0);
    chk("bp_done_ready", bus.pix_ready, 1);
    chk("bp_data_kept", bus.strip_data, vt[0].strip);
    tick();
    send(vt[3], 0, 6, 1'b0);
    send(ve, 0, W * H - 1, 1'b1);
    check_strip(ve);
    tick();
    chk("early_err_once", frame_err, 0);
    bus.strip_ready = 1'b1;
    tick();
    bus.strip_ready = 1'b0;
    bus.pix_valid = 1'b1; bus.pix_sof = 1'b0; bus.pix_data = 8'd200;
    tick();
    bus.pix_valid = 1'b0;
    chk("stray_err", frame_err, 1);
    chk("stray_valid", bus.strip_valid, 0);
    chk("stray_ready", bus.pix_ready, 1);
    tick();
    chk("stray_err_pulse", frame_err, 0);
    send(vt[1], 0, W * H - 1, 1'b0);
    chk("hold_before_rst", bus.strip_valid, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.strip_valid, 0);
    chk("async_rst_ready", bus.pix_ready, 0);
    chk("async_rst_data", bus.strip_data, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("no_stale_strip", bus.strip_valid, 0);
    end
    pos = 0;
    for (int c = 0; c < 4000; c++) begin
      bus.strip_ready = ($urandom % 3) == 0;
      bus.pix_valid = ($urandom % 5) != 0;
      bus.pix_data = 8'($urandom);
      if (pos == 0) begin
        threshold = 8'($urandom);
        col_sel = ($urandom % 10 < 8) ? 3'($urandom % 5) : 3'(5 + $urandom % 3);
      end
      bus.pix_sof = (pos == 0) ? (($urandom % 10) != 0) : (pos > 3 && ($urandom % 40) == 0);
      if (bus.pix_valid && bus.pix_ready)
        pos = bus.pix_sof ? 1 : (pos == 0 ? 0 : pos + 1);
      if (pos == W * H) pos = 0;
      tick();
    end
    bus.pix_valid = 1'b0; bus.pix_sof = 1'b0; bus.strip_ready = 1'b1;
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
